io_mmio_controller: RTL and testbench

Sequencer for the memory-mapped IO region (addr[31:30]==2'b10) of the 3-stage RISC-V core. It owns the UART transmit and receive handshakes and the four performance counters: cycle, retired instruction, retired branch and correctly predicted branch. It decodes core load/store requests into register reads, TX pushes, RX pops and counter resets. It returns read data with one-cycle latency, matching DMEM/BIOS timing, so the writeback mux treats all three sources alike.

---
 rtl/io_mmio_controller.sv | 154 +++++++++++++++
 tb/tb_io_mmio_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mmio_controller.sv
// rtl/io_mmio_controller.sv - IO window sequencer: UART TX/RX handshakes and performance counters
module io_mmio_controller #(
    parameter logic [31:0] IO_BASE = 32'h8000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        instr_retire,
    input  logic        br_retire,
    input  logic        br_correct,
    input  logic        uart_tx_ready,
    output logic        uart_tx_data_in_valid,
    output logic [7:0]  uart_tx_data_in,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_out,
    output logic        uart_rx_data_out_ready,
    output logic [31:0] io_rdata
);

    localparam logic [31:0] OFF_CTRL = 32'h00;
    localparam logic [31:0] OFF_RX   = 32'h04;
    localparam logic [31:0] OFF_TX   = 32'h08;
    localparam logic [31:0] OFF_CYC  = 32'h10;
    localparam logic [31:0] OFF_INS  = 32'h14;
    localparam logic [31:0] OFF_CLR  = 32'h18;
    localparam logic [31:0] OFF_BR   = 32'h1C;
    localparam logic [31:0] OFF_BRC  = 32'h20;

    typedef enum logic {
        TX_IDLE,
        TX_PEND
    } tx_state_t;

    tx_state_t          r_tx_state;
    tx_state_t          w_tx_state_nxt;
    logic               w_tx_load;
    logic [7:0]         r_tx_data;
    logic [31:0]        r_io_rdata;
    logic [31:0]        w_rdata;
    logic [CNT_W-1:0]   r_cyc_cnt;
    logic [CNT_W-1:0]   r_ins_cnt;
    logic [CNT_W-1:0]   r_br_cnt;
    logic [CNT_W-1:0]   r_brc_cnt;

    logic               w_io_hit;
    logic               w_io_ld;
    logic               w_io_st;
    logic [31:0]        w_off;
    logic               w_st_tx;
    logic               w_st_clr;
    logic               w_ld_rx;
    logic               w_tx_pend;
    logic               w_tx_free;
    logic               w_unused;

    assign w_io_hit  = req_valid && (req_addr[31:30] == 2'b10);
    assign w_io_ld   = w_io_hit && !req_we;
    assign w_io_st   = w_io_hit && req_we;
    assign w_off     = req_addr - IO_BASE;
    assign w_st_tx   = w_io_st && (w_off == OFF_TX);
    assign w_st_clr  = w_io_st && (w_off == OFF_CLR);
    assign w_ld_rx   = w_io_ld && (w_off == OFF_RX);
    assign w_tx_pend = (r_tx_state == TX_PEND);
    assign w_tx_free = uart_tx_ready && !w_tx_pend;
    assign w_unused  = ^req_wdata[31:8];

    assign uart_tx_data_in_valid  = w_tx_pend;
    assign uart_tx_data_in        = r_tx_data;
    assign uart_rx_data_out_ready = rst && w_ld_rx && uart_rx_valid;
    assign io_rdata               = r_io_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            if (w_tx_load) begin
                r_tx_data <= req_wdata[7:0];
            end
        end
    end

    // A store landing on the completing (ready) cycle is accepted back-to-back.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_st_tx) begin
                    w_tx_state_nxt = TX_PEND;
                    w_tx_load      = 1'b1;
                end
            end
            TX_PEND: begin
                if (uart_tx_ready) begin
                    if (w_st_tx) begin
                        w_tx_load = 1'b1;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            OFF_CTRL: w_rdata = {30'b0, uart_rx_valid, w_tx_free};
            OFF_RX:   w_rdata = {24'b0, uart_rx_out};
            OFF_CYC:  w_rdata = 32'(r_cyc_cnt);
            OFF_INS:  w_rdata = 32'(r_ins_cnt);
            OFF_BR:   w_rdata = 32'(r_br_cnt);
            OFF_BRC:  w_rdata = 32'(r_brc_cnt);
            default:  w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_io_rdata <= 32'h0;
        end else if (w_io_ld) begin
            r_io_rdata <= w_rdata;
        end
    end

    // The clear store takes priority over same-cycle increments.
    always_ff @(posedge clk) begin
        if (!rst || w_st_clr) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
            r_br_cnt  <= '0;
            r_brc_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            if (instr_retire) begin
                r_ins_cnt <= r_ins_cnt + CNT_W'(1);
            end
            if (br_retire) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (br_retire && br_correct) begin
                r_brc_cnt <= r_brc_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_io_mmio_controller.sv
// tb/tb_io_mmio_controller.sv - directed self-checking bench for io_mmio_controller
module tb_io_mmio_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        instr_retire;
    logic        br_retire;
    logic        br_correct;
    logic        uart_tx_ready;
    logic        uart_tx_data_in_valid;
    logic [7:0]  uart_tx_data_in;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_out;
    logic        uart_rx_data_out_ready;
    logic [31:0] io_rdata;

    int checks = 0;
    int errors = 0;

    io_mmio_controller dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_valid              (req_valid),
        .req_we                 (req_we),
        .req_addr               (req_addr),
        .req_wdata              (req_wdata),
        .instr_retire           (instr_retire),
        .br_retire              (br_retire),
        .br_correct             (br_correct),
        .uart_tx_ready          (uart_tx_ready),
        .uart_tx_data_in_valid  (uart_tx_data_in_valid),
        .uart_tx_data_in        (uart_tx_data_in),
        .uart_rx_valid          (uart_rx_valid),
        .uart_rx_out            (uart_rx_out),
        .uart_rx_data_out_ready (uart_rx_data_out_ready),
        .io_rdata               (io_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
    endtask

    task automatic set_load(input logic [31:0] addr);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        req_wdata = 32'h0;
    endtask

    task automatic set_store(input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_req();
        instr_retire = 1'b0; br_retire = 1'b0; br_correct = 1'b0;
        uart_tx_ready = 1'b0; uart_rx_valid = 1'b1; uart_rx_out = 8'hA5;
        set_load(32'h8000_0004);
        #1;
        checks++;
        if (uart_rx_data_out_ready !== 1'b0) begin
            $display("FAIL reset_rx_ready: got %b want 0", uart_rx_data_out_ready); errors++;
        end
        tick();
        tick();
        idle_req();
        uart_rx_valid = 1'b0;
        checks++;
        if (io_rdata !== 32'h0) begin
            $display("FAIL reset_rdata: got %h want 0", io_rdata); errors++;
        end
        checks++;
        if (uart_tx_data_in_valid !== 1'b0 || uart_tx_data_in !== 8'h00) begin
            $display("FAIL reset_tx: got valid %b data %h want 0/00", uart_tx_data_in_valid, uart_tx_data_in); errors++;
        end
        rst = 1'b1;
    endtask

    task automatic test_counter_read();
        for (int i = 0; i < 10; i++) tick();
        set_load(32'h8000_0010);
        tick();
        checks++;
        if (io_rdata !== 32'd10) begin
            $display("FAIL cycle_read: got %0d want 10", io_rdata); errors++;
        end
        set_load(32'h8000_0014);
        tick();
        checks++;
        if (io_rdata !== 32'd0) begin
            $display("FAIL instr_read: got %0d want 0", io_rdata); errors++;
        end
        set_load(32'h8000_0010);
        tick();
        set_load(32'h0000_1000);
        tick();
        checks++;
        if (io_rdata !== 32'd12) begin
            $display("FAIL non_io_hold: got %0d want 12", io_rdata); errors++;
        end
        set_load(32'h8000_000C);
        tick();
        checks++;
        if (io_rdata !== 32'd0) begin
            $display("FAIL unmapped_read: got %h want 0", io_rdata); errors++;
        end
        idle_req();
    endtask

    task automatic test_tx_pend();
        uart_tx_ready = 1'b0;
        set_store(32'h8000_0008, 32'hFFFF_FF41);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (uart_tx_data_in_valid !== 1'b1 || uart_tx_data_in !== 8'h41) begin
                $display("FAIL tx_hold_%0d: got valid %b data %h want 1/41", i, uart_tx_data_in_valid, uart_tx_data_in); errors++;
            end
            uart_tx_ready = (i == 3);
            if (i == 0) set_load(32'h8000_0000);
            else idle_req();
            tick();
            if (i == 0) begin
                checks++;
                if (io_rdata !== 32'h0) begin
                    $display("FAIL ctrl_pend: got %h want 0", io_rdata); errors++;
                end
            end
        end
        idle_req();
        checks++;
        if (uart_tx_data_in_valid !== 1'b0) begin
            $display("FAIL tx_drop: got %b want 0", uart_tx_data_in_valid); errors++;
        end
        uart_tx_ready = 1'b1;
        set_load(32'h8000_0000);
        tick();
        checks++;
        if (io_rdata !== 32'h1) begin
            $display("FAIL ctrl_free: got %h want 1", io_rdata); errors++;
        end
        idle_req();
    endtask

    task automatic test_back_to_back();
        uart_tx_ready = 1'b0;
        set_store(32'h8000_0008, 32'h41);
        tick();
        uart_tx_ready = 1'b1;
        set_store(32'h8000_0008, 32'h55);
        tick();
        checks++;
        if (uart_tx_data_in_valid !== 1'b1 || uart_tx_data_in !== 8'h55) begin
            $display("FAIL b2b_next: got valid %b data %h want 1/55", uart_tx_data_in_valid, uart_tx_data_in); errors++;
        end
        uart_tx_ready = 1'b0;
        set_store(32'h8000_0008, 32'h66);
        tick();
        checks++;
        if (uart_tx_data_in_valid !== 1'b1 || uart_tx_data_in !== 8'h55) begin
            $display("FAIL b2b_dropped: got valid %b data %h want 1/55", uart_tx_data_in_valid, uart_tx_data_in); errors++;
        end
        uart_tx_ready = 1'b1;
        idle_req();
        tick();
        checks++;
        if (uart_tx_data_in_valid !== 1'b0) begin
            $display("FAIL b2b_done: got %b want 0", uart_tx_data_in_valid); errors++;
        end
    endtask

    task automatic test_rx_pop();
        uart_rx_valid = 1'b1;
        uart_rx_out   = 8'h7E;
        set_load(32'h8000_0004);
        #1;
        checks++;
        if (uart_rx_data_out_ready !== 1'b1) begin
            $display("FAIL rx_pop: got %b want 1", uart_rx_data_out_ready); errors++;
        end
        tick();
        idle_req();
        #1;
        checks++;
        if (uart_rx_data_out_ready !== 1'b0 || io_rdata !== 32'h7E) begin
            $display("FAIL rx_data: got ready %b rdata %h want 0/7e", uart_rx_data_out_ready, io_rdata); errors++;
        end
        uart_rx_valid = 1'b0;
        uart_rx_out   = 8'h33;
        set_load(32'h8000_0004);
        #1;
        checks++;
        if (uart_rx_data_out_ready !== 1'b0) begin
            $display("FAIL rx_nopop: got %b want 0", uart_rx_data_out_ready); errors++;
        end
        tick();
        idle_req();
        checks++;
        if (io_rdata !== 32'h33) begin
            $display("FAIL rx_noval_data: got %h want 33", io_rdata); errors++;
        end
    endtask

    task automatic test_counters();
        logic [31:0] exp_seq [5];
        logic [31:0] addr_seq [5];
        exp_seq  = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
        addr_seq = '{32'h8000_0010, 32'h8000_0010, 32'h8000_0014, 32'h8000_001C, 32'h8000_0020};
        set_store(32'h8000_0018, 32'h0);
        tick();
        idle_req();
        for (int i = 0; i < 6; i++) begin
            br_retire  = (i < 5);
            br_correct = (i < 3) || (i == 5);
            instr_retire = 1'b1;
            tick();
        end
        br_retire = 1'b0; br_correct = 1'b0; instr_retire = 1'b0;
        set_load(32'h8000_001C);
        tick();
        checks++;
        if (io_rdata !== 32'd5) begin
            $display("FAIL br_cnt: got %0d want 5", io_rdata); errors++;
        end
        set_load(32'h8000_0020);
        tick();
        checks++;
        if (io_rdata !== 32'd3) begin
            $display("FAIL brc_cnt: got %0d want 3", io_rdata); errors++;
        end
        set_load(32'h8000_0014);
        tick();
        checks++;
        if (io_rdata !== 32'd6) begin
            $display("FAIL ins_cnt: got %0d want 6", io_rdata); errors++;
        end
        instr_retire = 1'b1; br_retire = 1'b1; br_correct = 1'b1;
        set_store(32'h8000_0018, 32'hDEAD_BEEF);
        tick();
        instr_retire = 1'b0; br_retire = 1'b0; br_correct = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_load(addr_seq[i]);
            tick();
            checks++;
            if (io_rdata !== exp_seq[i]) begin
                $display("FAIL clr_read_%0d: got %0d want %0d", i, io_rdata, exp_seq[i]); errors++;
            end
        end
        idle_req();
    endtask

    task automatic test_wrap_and_reset();
        force dut.r_cyc_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_cyc_cnt;
        set_load(32'h8000_0010);
        tick();
        tick();
        checks++;
        if (io_rdata !== 32'hFFFF_FFFF) begin
            $display("FAIL wrap_max: got %h want ffffffff", io_rdata); errors++;
        end
        tick();
        checks++;
        if (io_rdata !== 32'h0) begin
            $display("FAIL wrap_zero: got %h want 0", io_rdata); errors++;
        end
        uart_tx_ready = 1'b0;
        set_store(32'h8000_0008, 32'h41);
        tick();
        set_load(32'h8000_0010);
        tick();
        idle_req();
        checks++;
        if (uart_tx_data_in_valid !== 1'b1 || io_rdata !== 32'd2) begin
            $display("FAIL pre_rst: got valid %b rdata %h want 1/2", uart_tx_data_in_valid, io_rdata); errors++;
        end
        rst = 1'b0;
        tick();
        checks++;
        if (uart_tx_data_in_valid !== 1'b0 || io_rdata !== 32'h0 || uart_tx_data_in !== 8'h00) begin
            $display("FAIL mid_rst: got valid %b data %h rdata %h want 0/00/0", uart_tx_data_in_valid, uart_tx_data_in, io_rdata); errors++;
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_counter_read();
        test_tx_pend();
        test_back_to_back();
        test_rx_pop();
        test_counters();
        test_wrap_and_reset();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
